master_port_2k: RTL

Initiator-side bus port for the serial system bus: converts a parallel request from a master core (address, read/write, write data) into the bit-serial address/data/acknowledge sequence that the bus slaves answer, and returns read data in parallel. Sits between a master core and the bus arbiter/interconnect; it is the counterpart of the slave ports on the same B_* wires. Handles bus request/grant, address and data serialization, slave-acknowledge wait, read deserialization and bus holding for back-to-back transfers.

---
 rtl/master_port_2k_if.sv | 37 +++
 rtl/master_port_2k.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/master_port_2k_if.sv
// master_port_2k_if: core-side request/response and serial-bus wires
// of the bus master port, bundled with master (port) and slave views.
interface master_port_2k_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              m_execute;
  logic              m_rw;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_din;
  logic              m_hold;
  logic              m_bsy;
  logic              m_dvalid;
  logic [DATA_W-1:0] m_dout;
  logic              m_err;
  logic              b_req;
  logic              b_grant;
  logic              b_util;
  logic              b_rw;
  logic              b_bus_out;
  logic              b_bus_in;
  logic              b_ack;

  modport master (
    input  m_execute, m_rw, m_addr, m_din, m_hold,
    input  b_grant, b_bus_in, b_ack,
    output m_bsy, m_dvalid, m_dout, m_err,
    output b_req, b_util, b_rw, b_bus_out
  );

  modport slave (
    output m_execute, m_rw, m_addr, m_din, m_hold,
    output b_grant, b_bus_in, b_ack,
    input  m_bsy, m_dvalid, m_dout, m_err,
    input  b_req, b_util, b_rw, b_bus_out
  );
endinterface

// File: rtl/master_port_2k.sv
// master_port_2k: serial system bus initiator port (request/grant, serial
// addr/data, ack wait, read deserialize, hold). Option: ACK_TIMEOUT_EN.
module master_port_2k #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  master_port_2k_if.master bus
);
  localparam int SER = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int LIM = (SER > TIMEOUT) ? SER : TIMEOUT;
  localparam int CW  = $clog2(LIM + 1);

  typedef enum logic [2:0] {
    IDLE, REQ, ADDR, ACKA, WDATA, ACKW, RDATA, HOLD
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx, cnt_ack;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] dout_q;
  logic              rw_q;
  logic              dvalid_q;
  logic              err_q;
  logic              latch;
  logic              done;
  logic              tmo;
  logic              tmo_hit;
  logic              last_a;
  logic              last_d;

  assign last_a = (cnt == CW'(ADDR_W - 1));
  assign last_d = (cnt == CW'(DATA_W - 1));

`ifdef ACK_TIMEOUT_EN
  assign tmo_hit = !bus.b_ack && (cnt == CW'(TIMEOUT - 1));
  assign cnt_ack = cnt + 1'b1;
`else
  assign tmo_hit = 1'b0;
  assign cnt_ack = cnt;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    latch    = 1'b0;
    done     = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.m_execute) begin
          latch    = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (bus.b_grant) begin
          state_nx = ADDR;
          cnt_nx   = '0;
        end
      end
      ADDR: begin
        cnt_nx = cnt + 1'b1;
        if (last_a) begin
          state_nx = ACKA;
          cnt_nx   = '0;
        end
      end
      ACKA: begin
        if (bus.b_ack) begin
          state_nx = rw_q ? RDATA : WDATA;
          cnt_nx   = '0;
        end else if (tmo_hit) begin
          state_nx = IDLE;
          tmo      = 1'b1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_ack;
        end
      end
      WDATA: begin
        cnt_nx = cnt + 1'b1;
        if (last_d) begin
          state_nx = ACKW;
          cnt_nx   = '0;
        end
      end
      ACKW: begin
        if (bus.b_ack) begin
          done     = 1'b1;
          state_nx = bus.m_hold ? HOLD : IDLE;
          cnt_nx   = '0;
        end else if (tmo_hit) begin
          state_nx = IDLE;
          tmo      = 1'b1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_ack;
        end
      end
      RDATA: begin
        cnt_nx = cnt + 1'b1;
        if (last_d) begin
          done     = 1'b1;
          state_nx = bus.m_hold ? HOLD : IDLE;
          cnt_nx   = '0;
        end
      end
      HOLD: begin
        if (bus.m_execute) begin
          latch    = 1'b1;
          state_nx = bus.b_grant ? ADDR : REQ;
          cnt_nx   = '0;
        end else if (!bus.m_hold) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // addr/data registers shift right so bit 0 is always the serial output
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      rw_q     <= 1'b0;
      sr_q     <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      dvalid_q <= done;
      err_q    <= tmo;
      if (latch) begin
        addr_q <= bus.m_addr;
        din_q  <= bus.m_din;
        rw_q   <= bus.m_rw;
      end else if (state == ADDR) begin
        addr_q <= addr_q >> 1;
      end else if (state == WDATA) begin
        din_q <= din_q >> 1;
      end
      if (state == RDATA) begin
        sr_q <= {bus.b_bus_in, sr_q[DATA_W-1:1]};
        if (last_d) begin
          dout_q <= {bus.b_bus_in, sr_q[DATA_W-1:1]};
        end
      end
    end
  end

  always_comb begin
    bus.m_bsy     = !(state == IDLE || state == HOLD);
    bus.b_req     = (state != IDLE);
    bus.b_util    = state inside {ADDR, ACKA, WDATA, ACKW, RDATA};
    bus.b_rw      = bus.b_util && rw_q;
    bus.b_bus_out = 1'b0;
    if (state == ADDR) begin
      bus.b_bus_out = addr_q[0];
    end else if (state == WDATA) begin
      bus.b_bus_out = din_q[0];
    end
  end

  assign bus.m_dvalid = dvalid_q;
  assign bus.m_dout   = dout_q;

`ifdef ACK_TIMEOUT_EN
  assign bus.m_err = err_q;
`else
  assign bus.m_err = 1'b0;
`endif
endmodule
